// File: rtl/crc9_pkg.sv
// Shared constants, state type and bit-serial CRC-9 fold used by the
// crc9_128 encoder/decoder pair.
package crc9_pkg;

  localparam int DATA_W  = 128;
  localparam int CRC_W   = 9;
  localparam int CODE_W  = DATA_W + CRC_W;
  localparam int MAX_BPC = 32;

  // Coefficients x^8..x^0; the x^9 term is implicit.
  localparam logic [CRC_W-1:0] POLY_DEFAULT = 9'h119;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } enc_state_e;

  // Folds the low n bits of 'bits' into crc, bits[n-1] first.
  function automatic logic [CRC_W-1:0] crc9_step(
    input logic [CRC_W-1:0]   crc,
    input logic [MAX_BPC-1:0] bits,
    input int                 n,
    input logic [CRC_W-1:0]   poly = POLY_DEFAULT
  );
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = MAX_BPC - 1; i >= 0; i--) begin
      if (i < n) begin
        fb = bits[i] ^ c[CRC_W-1];
        c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc9_nbit_step.sv
// Combinational BPC-bit CRC-9 fold: chunk[BPC-1] is the first bit shifted in.
module crc9_nbit_step
  import crc9_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT,
  parameter int               BPC  = 8
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BPC-1:0]   chunk,
  output logic [CRC_W-1:0] crc_out
);

  logic [MAX_BPC-1:0] bits;

  always_comb begin
    bits             = '0;
    bits[BPC-1:0]    = chunk;
    crc_out          = crc9_step(crc_in, bits, BPC, POLY);
  end

endmodule

// File: rtl/crc9_128_enc.sv
// Multi-cycle CRC-9 encoder: accepts a 128-bit word, folds BPC bits per cycle
// and presents the 137-bit systematic codeword {data, crc}.
module crc9_128_enc
  import crc9_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT,
  parameter int               BPC  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [0:DATA_W-1]   i_data,
  output logic [0:CODE_W-1]   o_code,
  output logic                o_valid,
  input  logic                i_ready
);

  localparam int NCH   = DATA_W / BPC;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  enc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [0:DATA_W-1]  data_q,  data_d;
  logic [CRC_W-1:0]   crc_q,   crc_d;
  logic [0:CODE_W-1]  code_q,  code_d;
  logic               valid_q, valid_d;

  logic [0:DATA_W-1]  data_sh;
  logic [BPC-1:0]     chunk;
  logic [CRC_W-1:0]   crc_next;

  // Left shift moves chunk cnt to indices [0:BPC-1]; index 0 is the MSB.
  assign data_sh = data_q << (int'(cnt_q) * BPC);
  assign chunk   = data_sh[0:BPC-1];

  crc9_nbit_step #(
    .POLY (POLY),
    .BPC  (BPC)
  ) u_step (
    .crc_in  (crc_q),
    .chunk   (chunk),
    .crc_out (crc_next)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    crc_d   = crc_q;
    code_d  = code_q;
    valid_d = valid_q;
    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            data_d  = i_data;
            crc_d   = '0;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
        ST_CALC: begin
          crc_d = crc_next;
          if (cnt_q == CNT_W'(NCH - 1)) begin
            code_d  = {data_q, crc_next};
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the data and code registers are reset too, so a reset leaves no stale word visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      crc_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = valid_q;
  assign o_code  = code_q;

endmodule

// File: tb/tb_crc9_128_enc.sv
// Self-checking bench for crc9_128_enc: directed cases plus random words
// compared against a polynomial long-division model of the codeword.
module tb_crc9_128_enc;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic [136:0] o_code;
  logic         o_valid;
  logic         i_ready;

  int n_tests = 0;
  int n_fail  = 0;

  crc9_128_enc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_code  (o_code),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [136:0] got, input logic [136:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of v(x) divided by x^9+x^8+x^4+x^3+1.
  function automatic logic [8:0] poly_rem(input logic [136:0] v);
    logic [136:0] r;
    logic [136:0] g;
    r = v;
    for (int i = 136; i >= 9; i--) begin
      if (r[i]) begin
        g = 137'h319;
        r = r ^ (g << (i - 9));
      end
    end
    return r[8:0];
  endfunction

  function automatic logic [136:0] ref_code(input logic [127:0] d);
    return {d, poly_rem({d, 9'b0})};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!o_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!o_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Sends one word, optionally stalls enable for edges (stall_at, stall_at+stall_len],
  // optionally holds i_ready low for 'hold' cycles once the codeword appears.
  task automatic xfer(input logic [127:0] d, input int stall_at, input int stall_len,
                      input int exp_lat, input int hold, input string tag,
                      output logic [136:0] code_seen);
    int lat;
    bit seen;
    logic [136:0] exp;
    exp       = ref_code(d);
    code_seen = '0;
    i_ready   = (hold == 0);
    wait_ready(tag);
    i_data  = d;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = rand128();
    lat  = 0;
    seen = 0;
    for (int e = 1; e <= 200 && !seen; e++) begin
      enable = !(e > stall_at && e <= stall_at + stall_len);
      @(posedge clk); #1;
      if (o_valid) begin
        seen = 1;
        lat  = e;
      end
    end
    enable = 1'b1;
    if (!seen) begin
      check({tag, "_valid_timeout"}, 0, 1);
      i_ready = 1'b1;
      return;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_code"}, o_code, exp);
    code_seen = o_code;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_code"}, o_code, exp);
      check({tag, "_hold_ready"}, o_ready, 0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_post_valid"}, o_valid, 0);
    check({tag, "_post_ready"}, o_ready, 1);
  endtask

  initial begin
    logic [136:0] code;
    logic [127:0] d;
    logic [136:0] flip;
    int k;

    reset_n = 1'b0;
    enable  = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_code", o_code, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", o_ready, 1);

    xfer(128'h0, -1, 0, 16, 0, "zero", code);
    xfer(128'h1, -1, 0, 16, 0, "one", code);
    xfer(128'h2, -1, 0, 16, 0, "two", code);
    xfer(128'h3, -1, 0, 16, 0, "three", code);

    xfer(128'h1, -1, 0, 16, 5, "backpressure", code);

    xfer(128'h2, 5, 3, 19, 0, "stall", code);

    // Reset in the middle of a calculation.
    wait_ready("midrst");
    i_data  = rand128();
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    check("midrst_valid", o_valid, 0);
    check("midrst_code", o_code, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", o_ready, 1);
    check("midrst_valid_after", o_valid, 0);
    xfer(128'h1, -1, 0, 16, 0, "after_rst", code);

    for (int w = 0; w < 1000; w++) begin
      d = rand128();
      xfer(d, -1, 0, 16, 0, "rand", code);
      check("rand_data_field", code[136:9], d);
      check("rand_syndrome", poly_rem(code), 0);
      k    = $urandom_range(136, 0);
      flip = code;
      flip[k] = ~flip[k];
      check("rand_flip_detect", poly_rem(flip) != 9'd0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
